apb_regfile_completer: RTL and testbench
========================================

Name: apb_regfile_completer

Overview:
Parameterised APB4 completer fronting a register file. It generalises the team's first-generation APB slave with configurable register count, byte strobes and programmable wait states. It adds read-only status registers fed from hardware, decode and protection errors, and a flattened register-out bus for the surrounding logic. It sits on the peripheral APB segment behind the bridge and serves as the control/status block for one peripheral.

Parameters:
ADDR_WIDTH, 12, byte-address width of paddr
DATA_WIDTH, 32, data width; multiple of 8, power of 2, >=8
NUM_REGS, 16, number of registers; 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))
WAIT_STATES, 0, access-phase cycles with pready low before completion; 0..15
RO_MASK, 0, NUM_REGS-bit vector; bit i=1 makes register i read-only (hardware status)

Ports:
pclk  in  1  clock
preset  in  1  synchronous active-high reset
psel  in  1  completer select
penable  in  1  access phase
paddr  in  ADDR_WIDTH  byte address
pwrite  in  1  1=write, 0=read
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte strobes
prdata  out  DATA_WIDTH  read data, valid while pready=1
pready  out  1  transfer completion
pslverr  out  1  error response, valid while pready=1
hw_status  in  NUM_REGS*DATA_WIDTH  read value for RO registers; slice i belongs to register i
reg_out  out  NUM_REGS*DATA_WIDTH  current contents of RW registers; RO slices read 0

Behaviour:
- Reset: the design is one clock domain and reset is synchronous and active-high (preset sampled on pclk rising edge). At reset, all RW registers are 0, prdata=0, pready=0, pslverr=0, state=IDLE, and the wait counter is 0. Reset mid-transfer abandons the transfer; no write is committed.
- Decode: idx = paddr >> log2(DATA_WIDTH/8).
  - err_addr = paddr has nonzero low log2(DATA_WIDTH/8) bits (misaligned), or idx >= NUM_REGS.
  - err_ro = pwrite && RO_MASK[idx] && !err_addr.
  - err = err_addr | err_ro.
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
  - IDLE: on psel&&!penable (setup phase), the transfer starts.
    - If WAIT_STATES==0, go to DONE and assert pready next cycle.
    - Otherwise load cnt=WAIT_STATES and go to WAIT.
  - WAIT: while psel&&penable, decrement cnt each cycle. When cnt==1, go to DONE.
    - Result: exactly WAIT_STATES access cycles with pready=0, then one cycle with pready=1.
  - WAIT: if psel deasserts, abort to IDLE; no write, pready stays 0.
  - DONE: pready=1 for exactly one cycle; always return to IDLE. A back-to-back setup phase in the next cycle is accepted from IDLE.
- Completion values are registered on the edge entering DONE and held only during DONE; otherwise prdata=0 and pslverr=0.
  - Read, no error: prdata = RW register value, or hw_status slice if RO. pslverr=0.
  - Error: prdata=0, pslverr=1.
  - Write: prdata=0. pslverr=err.
- Write commit occurs on the edge entering DONE, only if !err. For each byte b with pstrb[b]=1, reg[idx][8b+7:8b] = pwdata byte b.
  - pstrb all zero: no change, no error.
  - RO registers are never written.
- Read data is sampled on the edge entering DONE. A read sees any write committed on an earlier edge.
- hw_status changes are visible on the next read; they are not latched otherwise.
- paddr, pwrite, pwdata and pstrb are sampled at the DONE-entry edge; the APB protocol requires them stable.
- A penable=1 in IDLE without a preceding setup phase is a protocol violation and is ignored; no response is produced.

Test Plan:
- Defaults, after reset: write 0xDEADBEEF to 0x008 with pstrb=0xF, then read 0x008. Both complete with pready in the first access cycle, pslverr=0, prdata=0xDEADBEEF, and reg_out slice 2=0xDEADBEEF.
- Byte strobes: reg 1=0x11223344; write 0xAABBCCDD with pstrb=0x5 → read returns 0x11BB33DD. Write with pstrb=0x0 → value unchanged, pslverr=0.
- WAIT_STATES=3: one transfer shows exactly 3 access cycles with pready=0, then 1 cycle with pready=1. Back-to-back read, write, read show no lost or duplicated completion.
- Errors: read 0x040 (idx 16, NUM_REGS=16) → pslverr=1, prdata=0. Write 0x006 (misaligned) → pslverr=1 and no register changes.
- RO_MASK=0x0001, hw_status slice 0=0xCAFE0001: read 0x000 → 0xCAFE0001. Write 0x000 → pslverr=1, and a subsequent read is still 0xCAFE0001.
- Robustness:
  - psel dropped during a WAIT phase (WAIT_STATES=2) → no write, no pready, and the next transfer completes normally.
  - preset asserted during WAIT → all outputs 0, RW registers 0 the next cycle.

Source files
------------

// File: rtl/apb_regfile_completer.sv
// apb_regfile_completer: APB4 completer over a byte-strobed register file with wait states and RO status slots.
// All bus outputs are registered and valid only during the single DONE cycle.
module apb_regfile_completer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BW);
    localparam int IW = ADDR_WIDTH - OFF;
    localparam int SW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [DATA_WIDTH-1:0] hw_arr [NUM_REGS];
    logic [IW-1:0]         idx;
    logic [SW-1:0]         sel;
    logic [NUM_REGS-1:0]   ro_sh;
    logic                  err_addr;
    logic                  err;
    logic                  done_d;
    logic [DATA_WIDTH-1:0] rd_d;

    assign idx = paddr[ADDR_WIDTH-1:OFF];
    assign sel = SW'(idx);
    assign ro_sh = RO_MASK >> idx;
    assign err_addr = (|(paddr & ADDR_WIDTH'(BW - 1))) || ({1'b0, idx} >= (IW+1)'(NUM_REGS));
    assign err = err_addr || (pwrite && ro_sh[0]);
    assign rd_d = ro_sh[0] ? hw_arr[sel] : regs_q[sel];
    // The edge that enters DONE is the one that commits writes and captures read data.
    assign done_d = psel && (state_q == IDLE ? !penable && WAIT_STATES == 0
                                             : state_q == WAIT && penable && cnt_q == 4'd1);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            prdata_q <= '0;
            pready_q <= 1'b0;
            pslverr_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            pready_q <= done_d;
            pslverr_q <= done_d && err;
            prdata_q <= (done_d && !pwrite && !err) ? rd_d : '0;
            if (done_d && pwrite && !err)
                for (int b = 0; b < BW; b++)
                    if (pstrb[b]) regs_q[sel][8*b +: 8] <= pwdata[8*b +: 8];
            case (state_q)
                IDLE: if (psel && !penable) begin
                    state_q <= WAIT_STATES == 0 ? DONE : WAIT;
                    cnt_q <= 4'(WAIT_STATES);
                end
                WAIT: if (!psel) state_q <= IDLE;
                      else if (penable) begin
                          state_q <= cnt_q == 4'd1 ? DONE : WAIT;
                          cnt_q <= cnt_q - 4'd1;
                      end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
        assign hw_arr[i] = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end

    assign prdata = prdata_q;
    assign pready = pready_q;
    assign pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_regfile_completer.sv
// tb_apb_regfile_completer: directed checks on three completers (0, 3 and 2 wait states) sharing one bus.
module tb_apb_regfile_completer;
    logic         clk = 1'b0;
    logic         preset = 1'b1;
    logic [2:0]   psel = '0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [11:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [511:0] hw = '0;
    logic [2:0]   pready;
    logic [2:0]   pslverr;
    logic [31:0]  prdata [3];
    logic [511:0] reg_out [3];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    apb_regfile_completer #(.WAIT_STATES(0), .RO_MASK(16'h0001)) u_ws0 (
        .pclk(clk), .preset(preset), .psel(psel[0]), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .hw_status(hw), .reg_out(reg_out[0]));
    apb_regfile_completer #(.WAIT_STATES(3)) u_ws3 (
        .pclk(clk), .preset(preset), .psel(psel[1]), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .hw_status(hw), .reg_out(reg_out[1]));
    apb_regfile_completer #(.WAIT_STATES(2)) u_ws2 (
        .pclk(clk), .preset(preset), .psel(psel[2]), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2]), .hw_status(hw), .reg_out(reg_out[2]));

    task automatic xfer(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd, output logic er, output int waits);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = s;
        @(posedge clk); #1 penable = 1'b1;
        waits = 0;
        while (!pready[d] && waits < 40) begin @(posedge clk); #1; waits++; end
        if (!pready[d]) begin mismatched++; $display("FAIL xfer_timeout: dut %0d pready=%b want 1", d, pready[d]); end
        compared++;
        rd = prdata[d]; er = pslverr[d];
        @(posedge clk); #1 psel[d] = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        preset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (pready !== 3'b000) begin mismatched++; $display("FAIL rst_pready: got %b want 000", pready); end
        compared++;
        if (pslverr !== 3'b000) begin mismatched++; $display("FAIL rst_pslverr: got %b want 000", pslverr); end
        compared++;
        for (int i = 0; i < 3; i++) begin
            if (prdata[i] !== 32'h0) begin mismatched++; $display("FAIL rst_prdata%0d: got %h want 0", i, prdata[i]); end
            compared++;
            if (reg_out[i] !== 512'h0) begin mismatched++; $display("FAIL rst_reg_out%0d: got nonzero want 0", i); end
            compared++;
        end
        preset = 1'b0;
    endtask

    task automatic test_defaults;
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 12'h008, 32'hDEADBEEF, 4'hF, rd, er, w);
        if (er !== 1'b0) begin mismatched++; $display("FAIL def_wr_err: got %b want 0", er); end
        compared++;
        if (w != 0) begin mismatched++; $display("FAIL def_wr_waits: got %0d want 0", w); end
        compared++;
        if (rd !== 32'h0) begin mismatched++; $display("FAIL def_wr_prdata: got %h want 0", rd); end
        compared++;
        xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL def_rd_data: got %h want deadbeef", rd); end
        compared++;
        if (er !== 1'b0 || w != 0) begin mismatched++; $display("FAIL def_rd_resp: got err=%b waits=%0d want 0/0", er, w); end
        compared++;
        if (reg_out[0][95:64] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL def_reg_out: got %h want deadbeef", reg_out[0][95:64]); end
        compared++;
        if (pready[0] !== 1'b0) begin mismatched++; $display("FAIL def_pready_drop: got %b want 0", pready[0]); end
        compared++;
    endtask

    task automatic test_strobes;
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 12'h004, 32'h11223344, 4'hF, rd, er, w);
        xfer(0, 1'b1, 12'h004, 32'hAABBCCDD, 4'h5, rd, er, w);
        if (er !== 1'b0) begin mismatched++; $display("FAIL strb_wr_err: got %b want 0", er); end
        compared++;
        xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'h11BB33DD) begin mismatched++; $display("FAIL strb_rd: got %h want 11bb33dd", rd); end
        compared++;
        xfer(0, 1'b1, 12'h004, 32'hFFFFFFFF, 4'h0, rd, er, w);
        if (er !== 1'b0) begin mismatched++; $display("FAIL strb0_err: got %b want 0", er); end
        compared++;
        xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'h11BB33DD) begin mismatched++; $display("FAIL strb0_rd: got %h want 11bb33dd", rd); end
        compared++;
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; logic er; int w;
        xfer(1, 1'b1, 12'h00C, 32'h12345678, 4'hF, rd, er, w);
        if (w != 3 || er !== 1'b0) begin mismatched++; $display("FAIL ws3_wr: got waits=%0d err=%b want 3/0", w, er); end
        compared++;
        if (pready[1] !== 1'b0) begin mismatched++; $display("FAIL ws3_pready_drop: got %b want 0", pready[1]); end
        compared++;
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'h12345678 || w != 3) begin mismatched++; $display("FAIL b2b_rd1: got %h waits=%0d want 12345678/3", rd, w); end
        compared++;
        xfer(1, 1'b1, 12'h00C, 32'h0F0F0F0F, 4'hF, rd, er, w);
        if (w != 3 || er !== 1'b0) begin mismatched++; $display("FAIL b2b_wr: got waits=%0d err=%b want 3/0", w, er); end
        compared++;
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'h0F0F0F0F || w != 3) begin mismatched++; $display("FAIL b2b_rd2: got %h waits=%0d want 0f0f0f0f/3", rd, w); end
        compared++;
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int w;
        logic [511:0] exp;
        exp = '0;
        exp[63:32] = 32'h11BB33DD;
        exp[95:64] = 32'hDEADBEEF;
        xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, rd, er, w);
        if (er !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL err_range_rd: got err=%b data=%h want 1/0", er, rd); end
        compared++;
        xfer(0, 1'b0, 12'h00A, 32'h0, 4'h0, rd, er, w);
        if (er !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL err_misal_rd: got err=%b data=%h want 1/0", er, rd); end
        compared++;
        xfer(0, 1'b1, 12'h006, 32'hFFFFFFFF, 4'hF, rd, er, w);
        if (er !== 1'b1) begin mismatched++; $display("FAIL err_misal_wr: got %b want 1", er); end
        compared++;
        if (reg_out[0] !== exp) begin mismatched++; $display("FAIL err_no_change: got %h want %h", reg_out[0][127:0], exp[127:0]); end
        compared++;
    endtask

    task automatic test_ro;
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'hCAFE0001 || er !== 1'b0) begin mismatched++; $display("FAIL ro_rd: got %h err=%b want cafe0001/0", rd, er); end
        compared++;
        xfer(0, 1'b1, 12'h000, 32'h12345678, 4'hF, rd, er, w);
        if (er !== 1'b1) begin mismatched++; $display("FAIL ro_wr_err: got %b want 1", er); end
        compared++;
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'hCAFE0001) begin mismatched++; $display("FAIL ro_rd_after: got %h want cafe0001", rd); end
        compared++;
        hw[31:0] = 32'hCAFE0002;
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'hCAFE0002) begin mismatched++; $display("FAIL ro_rd_live: got %h want cafe0002", rd); end
        compared++;
        if (reg_out[0][31:0] !== 32'h0) begin mismatched++; $display("FAIL ro_reg_out: got %h want 0", reg_out[0][31:0]); end
        compared++;
    endtask

    task automatic test_abort;
        logic [31:0] rd; logic er; int w;
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h55555555; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel[2] = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (pready[2] !== 1'b0) begin mismatched++; $display("FAIL abort_pready: got %b want 0", pready[2]); end
            compared++;
        end
        if (reg_out[2][159:128] !== 32'h0) begin mismatched++; $display("FAIL abort_no_write: got %h want 0", reg_out[2][159:128]); end
        compared++;
        xfer(2, 1'b1, 12'h010, 32'h00000099, 4'hF, rd, er, w);
        if (w != 2 || er !== 1'b0) begin mismatched++; $display("FAIL abort_next_wr: got waits=%0d err=%b want 2/0", w, er); end
        compared++;
        xfer(2, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'h00000099 || w != 2) begin mismatched++; $display("FAIL abort_next_rd: got %h waits=%0d want 99/2", rd, w); end
        compared++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int w;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h0000AAAA; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 preset = 1'b1;
        @(posedge clk); #1;
        if (pready !== 3'b000 || pslverr !== 3'b000) begin mismatched++; $display("FAIL rmid_resp: got pready=%b pslverr=%b want 000/000", pready, pslverr); end
        compared++;
        if (prdata[1] !== 32'h0) begin mismatched++; $display("FAIL rmid_prdata: got %h want 0", prdata[1]); end
        compared++;
        if (reg_out[1] !== 512'h0 || reg_out[0] !== 512'h0) begin mismatched++; $display("FAIL rmid_regs: got nonzero want 0"); end
        compared++;
        preset = 1'b0; psel[1] = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(1, 1'b0, 12'h014, 32'h0, 4'h0, rd, er, w);
        if (rd !== 32'h0 || w != 3 || er !== 1'b0) begin mismatched++; $display("FAIL rmid_after: got %h waits=%0d err=%b want 0/3/0", rd, w, er); end
        compared++;
    endtask

    initial begin
        hw[31:0] = 32'hCAFE0001;
        hw[63:32] = 32'hBAD0BAD1;
        test_reset;
        test_defaults;
        test_strobes;
        test_wait_states;
        test_errors;
        test_ro;
        test_abort;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
